// File: rtl/quad_decoder.sv
// Quadrature encoder front end: two-flop sync, per-channel debounce, Gray-code decode,
// detent accumulation and a one-cycle ce/dir step pulse. Optional err port: QUAD_ERR_EN.
module quad_decoder #(
    parameter int DEBOUNCE = 16,
    parameter int DETENT   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    output logic ce,
    output logic dir
`ifdef QUAD_ERR_EN
    ,
    output logic err
`endif
);

    localparam int              CW        = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0]   CNT_MAX   = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0]   CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic signed [3:0] ACC_POS = 4'(DETENT);
    localparam logic signed [3:0] ACC_NEG = -ACC_POS;

    localparam logic [1:0] STEP_NONE = 2'b00;
    localparam logic [1:0] STEP_FWD  = 2'b01;
    localparam logic [1:0] STEP_REV  = 2'b10;
    localparam logic [1:0] STEP_ILL  = 2'b11;

    // Bit 1 carries channel A, bit 0 channel B throughout.
    logic [1:0]        r_sync1;
    logic [1:0]        r_sync2;
    logic [1:0]        r_db;
    logic [1:0]        r_db_prev;
    logic [CW-1:0]     r_cnt [2];
    logic signed [3:0] r_acc;
    logic              r_ce;
    logic              r_dir;
    logic [1:0]        w_step;
    logic signed [3:0] w_acc_sum;

    function automatic logic [1:0] quad_step(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] res;
        case ({prev, cur})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: res = STEP_FWD;
            4'b0001, 4'b0111, 4'b1110, 4'b1000: res = STEP_REV;
            4'b0000, 4'b0101, 4'b1010, 4'b1111: res = STEP_NONE;
            default:                            res = STEP_ILL;
        endcase
        return res;
    endfunction

    // Two-stage synchroniser for the asynchronous pins; idle level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
        end else begin
            r_sync1 <= {a, b};
            r_sync2 <= r_sync1;
        end
    end

    // Independent debounce per channel: a new level must persist DEBOUNCE cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db      <= 2'b11;
            r_db_prev <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= CNT_ZERO;
            end
        end else begin
            r_db_prev <= r_db;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i] <= CNT_ZERO;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_db[i]  <= r_sync2[i];
                    r_cnt[i] <= CNT_ZERO;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Quarter-step decode and the tentative next accumulator value.
    always_comb begin
        w_step    = quad_step(r_db_prev, r_db);
        w_acc_sum = r_acc;
        case (w_step)
            STEP_FWD: w_acc_sum = r_acc + 4'sd1;
            STEP_REV: w_acc_sum = r_acc - 4'sd1;
            default:  w_acc_sum = r_acc;
        endcase
    end

    // Detent accumulator; a full detent either way emits one registered pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= 4'sd0;
            r_ce  <= 1'b0;
            r_dir <= 1'b0;
        end else if (w_step == STEP_ILL) begin
            r_acc <= 4'sd0;
            r_ce  <= 1'b0;
        end else if (w_acc_sum == ACC_POS) begin
            r_acc <= 4'sd0;
            r_ce  <= 1'b1;
            r_dir <= 1'b0;
        end else if (w_acc_sum == ACC_NEG) begin
            r_acc <= 4'sd0;
            r_ce  <= 1'b1;
            r_dir <= 1'b1;
        end else begin
            r_acc <= w_acc_sum;
            r_ce  <= 1'b0;
        end
    end

    assign ce  = r_ce;
    assign dir = r_dir;

`ifdef QUAD_ERR_EN
    logic r_err;

    // Illegal-transition flag, aligned with the accumulator clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (w_step == STEP_ILL);
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder (DEBOUNCE=4, DETENT=4): stimulus queues expected
// ce/err pulses with their cycle window, monitors pop and compare on every pulse.
module tb_quad_decoder;

    localparam int DEB = 4;
    localparam int DET = 4;
    localparam int LAT = 2 + DEB + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a   = 1'b1;
    logic b   = 1'b1;
    logic ce;
    logic dir;
`ifdef QUAD_ERR_EN
    logic err;
`endif

    typedef struct {
        int unsigned lo;
        int unsigned hi;
        logic        d;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned err_q[$];
    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          ce_seen = 0;

    quad_decoder #(.DEBOUNCE(DEB), .DETENT(DET)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .ce  (ce),
        .dir (dir)
`ifdef QUAD_ERR_EN
        ,
        .err (err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ce monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (ce === 1'b1) begin
            ce_seen++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ce: ce=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                vectors++;
                if (cyc < e.lo || cyc > e.hi) begin
                    miscompares++;
                    $display("FAIL ce_timing: pulse at cycle %0d, expected %0d..%0d", cyc, e.lo, e.hi);
                end
                check("ce_dir", {31'd0, dir}, {31'd0, e.d});
            end
        end
    end

`ifdef QUAD_ERR_EN
    // err monitor, same scheme as ce.
    always @(negedge clk) begin
        if (err === 1'b1) begin
            vectors++;
            if (err_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_err: err=1 at cycle %0d, expected none", cyc);
            end else begin
                int unsigned lo;
                lo = err_q.pop_front();
                if (cyc < lo || cyc > lo + 1) begin
                    miscompares++;
                    $display("FAIL err_timing: pulse at cycle %0d, expected %0d..%0d", cyc, lo, lo + 1);
                end
            end
        end
    end
`endif

    // Drive {a,b} for n cycles; queue a ce (and/or err) expectation for this edge.
    task automatic step(input logic [1:0] ab, input int n, input bit pulse, input logic d,
                        input bit ill);
        @(posedge clk);
        #1;
        {a, b} = ab;
        if (pulse) exp_q.push_back('{cyc + LAT, cyc + LAT + 1, d});
`ifdef QUAD_ERR_EN
        if (ill) err_q.push_back(cyc + LAT);
`else
        if (ill) begin end
`endif
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        a   = 1'b1;
        b   = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // 1: reset and idle
        do_reset(2);
        check("reset_ce", {31'd0, ce}, 32'd0);
        check("reset_dir", {31'd0, dir}, 32'd0);
`ifdef QUAD_ERR_EN
        check("reset_err", {31'd0, err}, 32'd0);
`endif
        step(2'b11, 100, 1'b0, 1'b0, 1'b0);
        check("idle_no_ce", ce_seen, 32'd0);

        // 2: forward detent
        step(2'b01, 10, 1'b0, 1'b0, 1'b0);
        step(2'b00, 10, 1'b0, 1'b0, 1'b0);
        step(2'b10, 10, 1'b0, 1'b0, 1'b0);
        step(2'b11, 10, 1'b1, 1'b0, 1'b0);
        check("fwd_count", ce_seen, 32'd1);
        check("fwd_dir_hold", {31'd0, dir}, 32'd0);

        // 3: reverse detent, dir must stay 1 afterwards
        step(2'b10, 10, 1'b0, 1'b0, 1'b0);
        step(2'b00, 10, 1'b0, 1'b0, 1'b0);
        step(2'b01, 10, 1'b0, 1'b0, 1'b0);
        step(2'b11, 10, 1'b1, 1'b1, 1'b0);
        step(2'b11, 20, 1'b0, 1'b0, 1'b0);
        check("rev_count", ce_seen, 32'd2);
        check("rev_dir_hold", {31'd0, dir}, 32'd1);

        // 4: 3-cycle glitch on a is discarded
        step(2'b01, 3, 1'b0, 1'b0, 1'b0);
        step(2'b11, 20, 1'b0, 1'b0, 1'b0);
        check("glitch_count", ce_seen, 32'd2);
        // Mid-detent glitch on both pins would clear the accumulator if accepted
        step(2'b01, 10, 1'b0, 1'b0, 1'b0);
        step(2'b00, 10, 1'b0, 1'b0, 1'b0);
        step(2'b11, 3, 1'b0, 1'b0, 1'b0);
        step(2'b00, 10, 1'b0, 1'b0, 1'b0);
        step(2'b10, 10, 1'b0, 1'b0, 1'b0);
        step(2'b11, 10, 1'b1, 1'b0, 1'b0);
        check("glitch_mid_count", ce_seen, 32'd3);
        // Phases of exactly DEBOUNCE cycles are still accepted
        step(2'b01, DEB, 1'b0, 1'b0, 1'b0);
        step(2'b00, DEB, 1'b0, 1'b0, 1'b0);
        step(2'b10, DEB, 1'b0, 1'b0, 1'b0);
        step(2'b11, 10, 1'b1, 1'b0, 1'b0);
        check("min_hold_count", ce_seen, 32'd4);

        // 5: two forward quarter-steps, back again, then one full detent
        step(2'b01, 10, 1'b0, 1'b0, 1'b0);
        step(2'b00, 10, 1'b0, 1'b0, 1'b0);
        step(2'b01, 10, 1'b0, 1'b0, 1'b0);
        step(2'b11, 10, 1'b0, 1'b0, 1'b0);
        check("reversal_no_ce", ce_seen, 32'd4);
        step(2'b01, 10, 1'b0, 1'b0, 1'b0);
        step(2'b00, 10, 1'b0, 1'b0, 1'b0);
        step(2'b10, 10, 1'b0, 1'b0, 1'b0);
        step(2'b11, 10, 1'b1, 1'b0, 1'b0);
        check("reversal_then_detent", ce_seen, 32'd5);

        // 6: illegal double change both ways, then reset mid-detent
        step(2'b00, 10, 1'b0, 1'b0, 1'b1);
        step(2'b11, 10, 1'b0, 1'b0, 1'b1);
        check("illegal_no_ce", ce_seen, 32'd5);
        step(2'b01, 10, 1'b0, 1'b0, 1'b0);
        do_reset(2);
        check("midrst_ce", {31'd0, ce}, 32'd0);
        step(2'b11, 20, 1'b0, 1'b0, 1'b0);
        check("midrst_no_ce", ce_seen, 32'd5);
        step(2'b01, 10, 1'b0, 1'b0, 1'b0);
        step(2'b00, 10, 1'b0, 1'b0, 1'b0);
        step(2'b10, 10, 1'b0, 1'b0, 1'b0);
        step(2'b11, 10, 1'b1, 1'b0, 1'b0);
        step(2'b11, 20, 1'b0, 1'b0, 1'b0);
        check("final_count", ce_seen, 32'd6);
        check("pending_ce", exp_q.size(), 32'd0);
`ifdef QUAD_ERR_EN
        check("pending_err", err_q.size(), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
